a2d_with_pots: RTL and testbench

- Synthesizable SPI-slave model of an 8-channel, 12-bit A2D converter with its slide potentiometers attached.
- Pot values arrive as parallel 12-bit inputs. The SPI master (equalizer top) requests a channel in one 16-bit frame and reads the conversion result in the following frame.
- Used in system benches and FPGA bring-up as the pot/volume source for the equalizer.

---
 rtl/a2d_with_pots.sv | 169 ++++++++++++++++
 tb/tb_a2d_with_pots.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/a2d_with_pots.sv
// a2d_with_pots: SPI-slave model of an 8-channel, 12-bit A2D converter whose
// inputs are slide potentiometers. The master sends a channel command in one
// 16-bit mode-0 frame and reads the converted value in the next frame.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   SS_n, SCLK, MOSI     asynchronous SPI inputs (synchronized internally)
//   MISO                 result bits, MSB first, zero padded to 16 bits
//   LP,B1,B2,B3,HP,VOL   parallel pot values (DATA_W bits each)
//   chnl                 channel of the last accepted command
//   frm_done             one-clk pulse when a valid frame closes
//
// Optional build macro A2D_NOISE_EN: a 16-bit LFSR (taps 16,15,13,4, seed
// 0xACE1) perturbs result bits [1:0]; it advances once per valid frame.
module a2d_with_pots #(
   parameter int unsigned DATA_W      = 12,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SS_n,
   input  logic              SCLK,
   input  logic              MOSI,
   output logic              MISO,
   input  logic [DATA_W-1:0] LP,
   input  logic [DATA_W-1:0] B1,
   input  logic [DATA_W-1:0] B2,
   input  logic [DATA_W-1:0] B3,
   input  logic [DATA_W-1:0] HP,
   input  logic [DATA_W-1:0] VOL,
   output logic [2:0]        chnl,
   output logic              frm_done
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
   logic                   ss_prev, sclk_prev;
   logic                   ss_s, sclk_s, mosi_s;
   logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;

   logic [15:0]       rx, tx, tx_load;
   logic [4:0]        cnt;
   logic [DATA_W-1:0] result, pot_sel, result_next;
   logic              frame_ok;

   // Synchronizers plus one extra flop per control line for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         ss_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_prev   <= 1'b1;
         sclk_prev <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         ss_prev   <= ss_s;
         sclk_prev <= sclk_s;
      end
   end

   assign ss_s      = ss_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign ss_fall   = ss_prev & ~ss_s;
   assign ss_rise   = ~ss_prev & ss_s;
   assign sclk_rise = ~sclk_prev & sclk_s;
   assign sclk_fall = sclk_prev & ~sclk_s;

   assign tx_load  = 16'(result);
   assign frame_ok = (cnt == 5'd16) && (rx[15:14] == 2'b00);

   always_comb begin
      pot_sel = '0;
      case (rx[13:11])
         3'd0:    pot_sel = B1;
         3'd1:    pot_sel = LP;
         3'd2:    pot_sel = B3;
         3'd3:    pot_sel = HP;
         3'd4:    pot_sel = B2;
         3'd7:    pot_sel = VOL;
         default: pot_sel = '0;
      endcase
   end

`ifdef A2D_NOISE_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= 16'hACE1;
      end else if (state == SHIFT && ss_rise && frame_ok) begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
      end
   end

   always_comb begin
      result_next      = pot_sel;
      result_next[1:0] = pot_sel[1:0] ^ lfsr[1:0];
   end
`else
   always_comb begin
      result_next = pot_sel;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (ss_fall) state_next = SHIFT;
         SHIFT:   if (ss_rise) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         MISO     <= 1'b0;
         chnl     <= 3'd0;
         frm_done <= 1'b0;
         result   <= '0;
         cnt      <= 5'd0;
         rx       <= '0;
         tx       <= '0;
      end else begin
         frm_done <= 1'b0;
         case (state)
            IDLE: begin
               MISO <= 1'b0;
               if (ss_fall) begin
                  tx   <= tx_load;
                  cnt  <= 5'd0;
                  MISO <= tx_load[15];
               end
            end
            SHIFT: begin
               if (ss_rise) begin
                  MISO <= 1'b0;
                  if (frame_ok) begin
                     chnl     <= rx[13:11];
                     result   <= result_next;
                     frm_done <= 1'b1;
                  end
               end else begin
                  if (sclk_rise) begin
                     rx <= {rx[14:0], mosi_s};
                     if (cnt != 5'd31) cnt <= cnt + 5'd1;
                  end
                  if (sclk_fall) begin
                     tx   <= {tx[14:0], 1'b0};
                     MISO <= tx[14];
                  end
               end
            end
            default: MISO <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_a2d_with_pots.sv
module tb_a2d_with_pots;

   logic        clk = 1'b0;
   logic        rst;
   logic        SS_n, SCLK, MOSI;
   logic        MISO;
   logic [11:0] LP, B1, B2, B3, HP, VOL;
   logic [2:0]  chnl;
   logic        frm_done;

   int tests  = 0;
   int failed = 0;
   int done_pulses = 0;

   logic [15:0] sb[$];

   typedef struct {
      logic [15:0] cmd;
      int          nclk;
      logic [15:0] exp_rd;
      logic [2:0]  exp_chnl;
      int          exp_done;
   } vec_t;

   vec_t vt[16];

   a2d_with_pots #(.DATA_W(12), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
      .LP(LP), .B1(B1), .B2(B2), .B3(B3), .HP(HP), .VOL(VOL),
      .chnl(chnl), .frm_done(frm_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frm_done) done_pulses++;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic ss_low();
      SS_n = 1'b0;
      wait_clk(8);
   endtask

   task automatic ss_high();
      wait_clk(8);
      SS_n = 1'b1;
      wait_clk(12);
   endtask

   task automatic clock_bit(input logic b, output logic m);
      MOSI = b;
      wait_clk(8);
      m = MISO;
      SCLK = 1'b1;
      wait_clk(8);
      SCLK = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] cmd, input int n,
                            output logic [15:0] rd, output logic extra);
      logic m;
      rd = '0;
      extra = 1'b0;
      for (int i = 0; i < n; i++) begin
         clock_bit((i < 16) ? cmd[15-i] : 1'b0, m);
         if (i < 16) rd[15-i] = m;
         else        extra = extra | m;
      end
   endtask

   task automatic run_frame(input string name, input logic [15:0] cmd, input int n,
                            input logic [15:0] exp_rd, input logic [2:0] exp_chnl,
                            input int exp_done);
      logic [15:0] rd, exp;
      logic        extra;
      sb.push_back(exp_rd);
      done_pulses = 0;
      ss_low();
      send_bits(cmd, n, rd, extra);
      ss_high();
      exp = sb.pop_front();
      check({name, " rd"}, rd, exp);
      check({name, " chnl"}, chnl, exp_chnl);
      check({name, " done"}, done_pulses, exp_done);
      if (n > 16) check({name, " tail"}, extra, 1'b0);
   endtask

   initial begin
      logic [15:0] rd;
      logic        extra;

      vt[0]  = '{16'h0000, 16, 16'h0000, 3'd0, 1};
      vt[1]  = '{16'h3800, 16, 16'h0123, 3'd7, 1};
      vt[2]  = '{16'h0000, 16, 16'h0100, 3'd0, 1};
      vt[3]  = '{16'h0800, 16, 16'h0123, 3'd1, 1};
      vt[4]  = '{16'h0000, 16, 16'h0ABC, 3'd0, 1};
      vt[5]  = '{16'h2000, 16, 16'h0123, 3'd4, 1};
      vt[6]  = '{16'h1000, 16, 16'h0456, 3'd2, 1};
      vt[7]  = '{16'h1800, 16, 16'h0789, 3'd3, 1};
      vt[8]  = '{16'h0000, 16, 16'h0FED, 3'd0, 1};
      vt[9]  = '{16'h0800, 12, 16'h0120, 3'd0, 0};
      vt[10] = '{16'h8800, 16, 16'h0123, 3'd0, 0};
      vt[11] = '{16'h2800, 16, 16'h0123, 3'd5, 1};
      vt[12] = '{16'h0000, 16, 16'h0000, 3'd0, 1};
      vt[13] = '{16'h1000, 20, 16'h0123, 3'd0, 0};
      vt[14] = '{16'h0000,  0, 16'h0000, 3'd0, 0};
      vt[15] = '{16'h0000, 16, 16'h0123, 3'd0, 1};

      rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
      LP = 12'hABC; B1 = 12'h123; B2 = 12'h456; B3 = 12'h789; HP = 12'hFED; VOL = 12'h100;
      wait_clk(5);
      check("reset MISO", MISO, 1'b0);
      check("reset chnl", chnl, 3'd0);
      check("reset frm_done", frm_done, 1'b0);
      rst = 1'b0;
      wait_clk(5);

      for (int i = 0; i < 16; i++)
         run_frame($sformatf("vec%0d", i), vt[i].cmd, vt[i].nclk,
                   vt[i].exp_rd, vt[i].exp_chnl, vt[i].exp_done);

      // Pot sampled at SS_n rise: change LP after the last SCLK of the command.
      sb.push_back(16'h0123);
      done_pulses = 0;
      ss_low();
      send_bits(16'h0800, 16, rd, extra);
      LP = 12'h555;
      ss_high();
      check("late pot rd", rd, sb.pop_front());
      check("late pot chnl", chnl, 3'd1);
      // Mid-frame pot change must not disturb the bits already loaded.
      sb.push_back(16'h0555);
      ss_low();
      send_bits(16'h0000, 4, rd, extra);
      LP = 12'h0AA;
      begin
         logic [15:0] rd2;
         send_bits(16'h0000, 12, rd2, extra);
         rd = {rd[15:12], rd2[15:4]};
      end
      ss_high();
      check("midframe pot rd", rd, sb.pop_front());

      // SCLK activity with SS_n high is ignored; MISO stays low.
      for (int i = 0; i < 6; i++) begin
         SCLK = 1'b1; wait_clk(4); SCLK = 1'b0; wait_clk(4);
      end
      check("idle sclk MISO", MISO, 1'b0);
      check("idle sclk chnl", chnl, 3'd0);
      run_frame("after idle sclk", 16'h3800, 16, 16'h0123, 3'd7, 1);

      // Reset in the middle of a frame.
      sb.push_back(16'h0100);
      ss_low();
      send_bits(16'h0000, 7, rd, extra);
      check("pre-reset partial rd", rd, {sb.pop_front() & 16'hFE00});
      rst = 1'b1;
      wait_clk(2);
      check("midrst MISO", MISO, 1'b0);
      check("midrst chnl", chnl, 3'd0);
      SS_n = 1'b1;
      wait_clk(5);
      rst = 1'b0;
      wait_clk(10);
      run_frame("post-reset", 16'h0000, 16, 16'h0000, 3'd0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
